// File: rtl/usb_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_phy_pkg
// Description : Shared PIPE status codes, symbol codes and elastic-buffer
//               entry layout for the USB 3.0 PHY receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_phy_pkg;

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_SKP_ADD = 3'b001;
    localparam logic [2:0] ST_SKP_RM  = 3'b010;
    localparam logic [2:0] ST_DEC_ERR = 3'b100;
    localparam logic [2:0] ST_OVF     = 3'b101;
    localparam logic [2:0] ST_UNF     = 3'b110;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h3C;

    // Per-entry sideband that sits above the data field in every buffer word.
    typedef struct packed {
        logic [2:0] status;
        logic       k;
    } ebuf_tag_t;

    // Full entry for the native 8-bit symbol width.
    typedef struct packed {
        logic [2:0] status;
        logic       k;
        logic [7:0] data;
    } ebuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/usb_phy_ebuf_ram.sv
`default_nettype none
// ============================================================================
// Module      : usb_phy_ebuf_ram
// Description : Elastic-buffer storage; synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_phy_ebuf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/usb_phy_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module      : usb_phy_elastic_buf
// Description : PIPE receive elastic buffer with SKP add/remove clock
//               compensation, polarity inversion and status reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_phy_elastic_buf
    import usb_phy_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 16,
    parameter int                HI_MARK = 12,
    parameter int                LO_MARK = 4,
    parameter logic [DATA_W-1:0] SKP_SYM = DATA_W'(K_SKP)
) (
    input  logic                     PHY_CLK,
    input  logic                     PHY_RST,
    input  logic                     PHY_CLR,
    input  logic                     RX_WINC,
    input  logic [DATA_W-1:0]        WR_DATA,
    input  logic                     WR_DATAK,
    input  logic                     WR_ERR,
    input  logic                     RX_RINC,
    input  logic                     RX_POLARITY,
    output logic [DATA_W-1:0]        RX_DATA,
    output logic                     RX_DATAK,
    output logic                     RX_VALID,
    output logic [2:0]               RX_STATUS,
    output logic [$clog2(DEPTH):0]   FILL
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          EW        = DATA_W + 4;
    localparam logic [AW:0] c_one     = (AW+1)'(1);
    localparam logic [AW:0] c_hi_mark = (AW+1)'(HI_MARK);
    localparam logic [AW:0] c_lo_mark = (AW+1)'(LO_MARK);

    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [AW:0]        r_fill;
    logic               r_pend_rm;
    logic               r_pend_ovf;
    logic               r_ins_done;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_datak;
    logic               r_rx_valid;
    logic [2:0]         r_rx_status;

    logic [EW-1:0]      w_head;
    logic [EW-1:0]      w_wr_entry;
    ebuf_tag_t          w_head_tag;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_head_skp;
    logic               w_ins_first;
    logic               w_pop;
    logic               w_wr_skp;
    logic               w_skp_rm;
    logic               w_ovf;
    logic               w_push;
    logic [2:0]         w_wr_status;
    logic [2:0]         w_rd_status;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_head_tag  = ebuf_tag_t'(w_head[EW-1:DATA_W]);
    assign w_head_data = w_head[DATA_W-1:0];

    always_comb begin
        w_run       = !PHY_RST && !PHY_CLR;
        w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_empty     = (r_wptr == r_rptr);

        // First read of a SKP while running low: present it but keep it at the head.
        w_head_skp  = w_head_tag.k && (w_head_data == SKP_SYM);
        w_ins_first = w_head_skp && (r_fill <= c_lo_mark) && !r_ins_done;
        w_pop       = w_run && RX_RINC && !w_empty && !w_ins_first;

        w_wr_skp    = WR_DATAK && (WR_DATA == SKP_SYM);
        w_skp_rm    = w_run && RX_WINC && w_wr_skp && (r_fill >= c_hi_mark);
        w_ovf       = w_run && RX_WINC && !w_skp_rm && w_full && !w_pop;
        w_push      = w_run && RX_WINC && !w_skp_rm && !w_ovf;

        if (WR_ERR) begin
            w_wr_status = ST_DEC_ERR;
        end else if (r_pend_ovf) begin
            w_wr_status = ST_OVF;
        end else if (r_pend_rm) begin
            w_wr_status = ST_SKP_RM;
        end else begin
            w_wr_status = ST_OK;
        end
        w_wr_entry = {w_wr_status, WR_DATAK, WR_DATA};

        // Repeated SKP reports the addition unless an error code already rides on it.
        if (r_ins_done && (w_head_tag.status != ST_DEC_ERR) && (w_head_tag.status != ST_OVF)) begin
            w_rd_status = ST_SKP_ADD;
        end else begin
            w_rd_status = w_head_tag.status;
        end

        w_rd_data = (RX_POLARITY && !w_head_tag.k) ? ~w_head_data : w_head_data;
    end

    usb_phy_ebuf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk       (PHY_CLK),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_data (w_head)
    );

    always_ff @(posedge PHY_CLK) begin
        if (PHY_RST || PHY_CLR) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_pend_rm   <= 1'b0;
            r_pend_ovf  <= 1'b0;
            r_ins_done  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_datak  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_status <= ST_OK;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_one;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + c_one;
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - c_one;
            end

            // A stored symbol carries the highest pending code; all pending flags are retired.
            if (w_push) begin
                r_pend_rm  <= 1'b0;
                r_pend_ovf <= 1'b0;
            end
            if (w_skp_rm) begin
                r_pend_rm <= 1'b1;
            end
            if (w_ovf) begin
                r_pend_ovf <= 1'b1;
            end

            if (RX_RINC && !w_empty) begin
                r_ins_done <= w_ins_first;
            end

            if (RX_RINC) begin
                r_rx_valid  <= !w_empty;
                r_rx_data   <= w_empty ? '0 : w_rd_data;
                r_rx_datak  <= !w_empty && w_head_tag.k;
                r_rx_status <= w_empty ? ST_UNF : w_rd_status;
            end else begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign RX_DATA   = r_rx_data;
    assign RX_DATAK  = r_rx_datak;
    assign RX_VALID  = r_rx_valid;
    assign RX_STATUS = r_rx_status;
    assign FILL      = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_usb_phy_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_phy_elastic_buf
// Description : Directed and randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_phy_elastic_buf;
    import usb_phy_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       winc = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_k = 1'b0;
    logic       wr_err = 1'b0;
    logic       rinc = 1'b0;
    logic       pol = 1'b0;
    logic [7:0] rx_data;
    logic       rx_datak;
    logic       rx_valid;
    logic [2:0] rx_status;
    logic [4:0] fill;

    usb_phy_elastic_buf dut (
        .PHY_CLK     (clk),
        .PHY_RST     (rst),
        .PHY_CLR     (clr),
        .RX_WINC     (winc),
        .WR_DATA     (wr_data),
        .WR_DATAK    (wr_k),
        .WR_ERR      (wr_err),
        .RX_RINC     (rinc),
        .RX_POLARITY (pol),
        .RX_DATA     (rx_data),
        .RX_DATAK    (rx_datak),
        .RX_VALID    (rx_valid),
        .RX_STATUS   (rx_status),
        .FILL        (fill)
    );

    always #5 clk = ~clk;

    ebuf_entry_t q[$];
    bit          m_rm;
    bit          m_ovf;
    bit          m_ins;
    logic [7:0]  e_data;
    logic        e_k;
    logic        e_valid;
    logic [2:0]  e_status;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Buffer behaviour as a FIFO queue of symbols with watermark rules.
    task automatic model_step();
        int          f;
        bit          pop;
        ebuf_entry_t h;
        ebuf_entry_t e;
        if (rst || clr) begin
            q.delete();
            m_rm = 0; m_ovf = 0; m_ins = 0;
            e_data = 8'h00; e_k = 1'b0; e_valid = 1'b0; e_status = ST_OK;
            return;
        end
        f = q.size();
        pop = 0;
        if (rinc) begin
            if (f == 0) begin
                e_valid = 1'b0; e_data = 8'h00; e_k = 1'b0; e_status = ST_UNF;
            end else begin
                h = q[0];
                if (m_ins) begin
                    e_status = (h.status == ST_DEC_ERR || h.status == ST_OVF) ? h.status : ST_SKP_ADD;
                    m_ins = 0;
                    pop = 1;
                end else if (h.k && h.data == 8'h3C && f <= 4) begin
                    e_status = h.status;
                    m_ins = 1;
                end else begin
                    e_status = h.status;
                    pop = 1;
                end
                e_valid = 1'b1;
                e_k = h.k;
                e_data = (pol && !h.k) ? ~h.data : h.data;
            end
        end else begin
            e_valid = 1'b0;
        end
        if (winc) begin
            if (wr_k && wr_data == 8'h3C && f >= 12) begin
                m_rm = 1;
            end else if (f == 16 && !pop) begin
                m_ovf = 1;
            end else begin
                e.data = wr_data;
                e.k = wr_k;
                e.status = wr_err ? ST_DEC_ERR : (m_ovf ? ST_OVF : (m_rm ? ST_SKP_RM : ST_OK));
                m_rm = 0; m_ovf = 0;
                q.push_back(e);
            end
        end
        if (pop) void'(q.pop_front());
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit k, input bit er,
                         input bit r, input bit p);
        winc = w; wr_data = d; wr_k = k; wr_err = er; rinc = r; pol = p;
        @(posedge clk);
        model_step();
        #1;
        check_val("valid", rx_valid, e_valid);
        check_val("data", rx_data, e_data);
        check_val("datak", rx_datak, e_k);
        check_val("status", rx_status, e_status);
        check_val("fill", fill, q.size());
    endtask

    task automatic wr(input logic [7:0] d, input bit k, input bit er);
        cycle(1'b1, d, k, er, 1'b0, 1'b0);
    endtask

    task automatic rd(input bit p);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        bit         k;
        int         wp;
        int         rp;

        rst = 1'b1;
        idle(); idle();
        rst = 1'b0;
        check_val("rst_fill", fill, 0);

        for (int i = 0; i < 5; i++) wr(8'(i + 1), 1'b0, 1'b0);
        clr = 1'b1; rd(1'b0); clr = 1'b0;
        check_val("clr_out", {rx_valid, rx_datak, rx_status, rx_data, fill}, 0);
        rd(1'b0);
        check_val("clr_unf", rx_status, ST_UNF);

        wr(K_COM, 1'b1, 1'b0); wr(8'hFF, 1'b0, 1'b0); wr(8'h17, 1'b0, 1'b0); wr(8'hC0, 1'b0, 1'b0);
        rd(1'b0);
        check_val("basic_first", {rx_valid, rx_datak, rx_data}, {2'b11, 8'hBC});
        rd(1'b0); rd(1'b0); rd(1'b0);
        check_val("basic_last", {rx_datak, rx_status, rx_data}, {4'b0000, 8'hC0});

        for (int i = 0; i < 12; i++) wr(8'($urandom), 1'b0, 1'b0);
        wr(K_SKP, 1'b1, 1'b0);
        check_val("rm_fill", fill, 12);
        wr(8'h14, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) rd(1'b0);
        check_val("rm_status", {rx_status, rx_data}, {ST_SKP_RM, 8'h14});

        wr(K_SKP, 1'b1, 1'b0); wr(8'h55, 1'b0, 1'b0);
        rd(1'b0);
        check_val("ins_first", {rx_datak, rx_status, rx_data}, {1'b1, ST_OK, 8'h3C});
        rd(1'b0);
        check_val("ins_second", {rx_datak, rx_status, rx_data}, {1'b1, ST_SKP_ADD, 8'h3C});
        rd(1'b0);
        check_val("ins_next", rx_data, 8'h55);

        for (int i = 0; i < 16; i++) wr(8'(i + 32), 1'b0, 1'b0);
        wr(8'hA6, 1'b0, 1'b0);
        check_val("ovf_fill", fill, 16);
        rd(1'b0);
        wr(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) rd(1'b0);
        check_val("ovf_status", {rx_status, rx_data}, {ST_OVF, 8'h77});
        rd(1'b0);
        check_val("unf", {rx_valid, rx_status}, {1'b0, ST_UNF});

        wr(8'h14, 1'b0, 1'b0); wr(K_COM, 1'b1, 1'b0);
        rd(1'b1);
        check_val("pol_data", rx_data, 8'hEB);
        rd(1'b1);
        check_val("pol_k", {rx_datak, rx_data}, {1'b1, 8'hBC});
        for (int i = 0; i < 12; i++) wr(8'($urandom), 1'b0, 1'b0);
        wr(K_SKP, 1'b1, 1'b0);
        wr(8'h99, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) rd(1'b0);
        check_val("err_status", {rx_status, rx_data}, {ST_DEC_ERR, 8'h99});

        for (int ph = 0; ph < 9; ph++) begin
            wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 55);
            rp = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 50);
            for (int c = 0; c < 400; c++) begin
                rst = ($urandom_range(0, 999) < 3);
                clr = ($urandom_range(0, 999) < 6);
                k = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0, 1:    d = K_SKP;
                    2:       d = K_COM;
                    default: d = 8'($urandom);
                endcase
                if (!k) d = 8'($urandom);
                cycle($urandom_range(0, 99) < wp, d, k, $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < rp, 1'($urandom));
            end
        end
        rst = 1'b0; clr = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_phy_elastic_buf.md
# usb_phy_elastic_buf

Parametrised receive elastic buffer for the USB 3.0 PHY receive path, sitting between the 8b/10b decoder output and the PIPE receive interface (RX_DATA/RX_DATAK/RX_STATUS/RX_VALID). It generalises the fixed 8-bit buffer to configurable symbol width, depth and fill watermarks. It adds SKP ordered-symbol insertion/removal for clock compensation, receive polarity inversion, decode-error passthrough, and PIPE-coded overflow/underflow reporting.

## Interface
- DATA_W, 8, symbol data width.
- DEPTH, 16, entry count; power of two, ≥4.
- HI_MARK, 12, fill level at/above which an incoming SKP is dropped.
- LO_MARK, 4, fill level at/below which an outgoing SKP is repeated; LO_MARK < HI_MARK ≤ DEPTH.
- SKP_SYM, 8'h3C, K28.1 SKP code, compared when the K flag is set.
- Clocking: one clock; reset is synchronous and active-high.
- PHY_CLK  in  1  single clock; all logic on the rising edge.
- PHY_RST  in  1  synchronous, active-high reset.
- PHY_CLR  in  1  synchronous flush.
- RX_WINC  in  1  write strobe for WR_DATA/WR_DATAK/WR_ERR.
- WR_DATA  in  DATA_W  decoded symbol.
- WR_DATAK  in  1  K-symbol flag.
- WR_ERR  in  1  8b/10b decode/disparity error for this symbol.
- RX_RINC  in  1  read strobe.
- RX_POLARITY  in  1  invert data symbols on output.
- RX_DATA  out  DATA_W  output symbol.
- RX_DATAK  out  1  output K flag.
- RX_VALID  out  1  output symbol valid.
- RX_STATUS  out  3  PIPE status code.
- FILL  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Entry = {status[2:0], k, data}. Write/read pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the rest are equal. Empty when the pointers are equal.
- Write when RX_WINC=1:
  - If WR_DATAK=1, WR_DATA==SKP_SYM and FILL≥HI_MARK: the symbol is not stored and pend_rm is set.
  - Else if full and no pop this cycle: the symbol is dropped and pend_ovf is set.
  - Else the symbol is stored. Its status field takes the priority 100 (WR_ERR) > 101 (pend_ovf) > 010 (pend_rm) > 000. The consumed pending flags are cleared.
- Read when RX_RINC=1:
  - Not empty: the head entry is registered to the outputs and RX_VALID=1.
  - If the head is SKP, FILL≤LO_MARK and ins_done=0: the read pointer does not advance, the output status is the stored status, and ins_done is set. The following read outputs the same SKP with status 001 (unless the stored status is 100/101), advances the pointer and clears ins_done. At most one insertion per SKP entry.
  - Empty: underflow. RX_VALID=0, RX_DATA=0, RX_DATAK=0, RX_STATUS=110.
  - RX_RINC=0: RX_VALID=0 next cycle, and RX_DATA/RX_DATAK/RX_STATUS hold.
- Polarity: when RX_POLARITY=1 at the read cycle and the entry's k=0, RX_DATA = ~data. K symbols are never inverted.
- Simultaneous read and write:
  - When full, the pop frees the slot and the write succeeds.
  - When empty, the read underflows (no bypass) and the write is stored.
- PHY_CLR: pointers, pending flags and ins_done are zeroed, and outputs go to their reset values next cycle. PHY_CLR overrides RX_WINC/RX_RINC in the same cycle.
- PHY_RST overrides everything, including PHY_CLR.

## Timing
- Reset values: RX_DATA=0, RX_DATAK=0, RX_VALID=0, RX_STATUS=000, FILL=0.
- Write latency: a symbol written in cycle N can be popped by RX_RINC in cycle N+1.
- Read latency: RX_RINC in cycle N gives the output valid in cycle N+1 (registered).
- FILL is registered and updates the cycle after a push/pop. Push+pop in the same cycle leaves FILL unchanged.
- Watermark compares use the registered FILL.
- Reset or flush mid-packet discards all content. No status is reported for the lost data.

## Structure
- Shared package usb_phy_pkg:
  - Status code constants: ST_OK 000, ST_SKP_ADD 001, ST_SKP_RM 010, ST_DEC_ERR 100, ST_OVF 101, ST_UNF 110.
  - Symbol constants: K_COM 8'hBC, K_SKP 8'h3C.
  - Entry struct typedef.
- Sub-module usb_phy_ebuf_ram: DEPTH × (DATA_W+4) register array with synchronous write and asynchronous read.
- Control, pointers, SKP logic and the output register live in usb_phy_elastic_buf.

## Test plan
- Reset/flush: assert PHY_RST, then PHY_CLR with 5 entries stored → all outputs 0 and FILL=0 the next cycle; a subsequent read gives ST_UNF.
- Basic path: write BC(K), FF, 17, C0, then four reads → outputs in order, RX_DATAK=1 only on BC, status 000, one-cycle read latency.
- SKP removal: fill to 12, write 3C(K) then 14 → FILL stays 12 after the SKP; 14 is later read with status 010.
- SKP insertion: FILL=2 with head 3C(K) → two consecutive reads both return 3C(K), the second with 001; the third read returns the next entry.
- Overflow/underflow: 16 writes, then A6 with no read → A6 dropped; the next stored symbol reads with 101. Draining and one extra read → RX_VALID=0, RX_STATUS=110.
- Polarity/error: RX_POLARITY=1, read stored 14 and BC(K) → EB and BC. Write with WR_ERR=1 → status 100, which also overrides a pending SKP-removal flag.
